// File: rtl/proj4_pkg.sv
// Shared constants and types for the parking-meter seven-segment display.
// Segment patterns are active-low, ordered {g,f,e,d,c,b,a}.
package proj4_pkg;

    localparam logic [6:0] SEG_0     = 7'b1000000;
    localparam logic [6:0] SEG_1     = 7'b1111001;
    localparam logic [6:0] SEG_2     = 7'b0100100;
    localparam logic [6:0] SEG_3     = 7'b0110000;
    localparam logic [6:0] SEG_4     = 7'b0011001;
    localparam logic [6:0] SEG_5     = 7'b0010010;
    localparam logic [6:0] SEG_6     = 7'b0000010;
    localparam logic [6:0] SEG_7     = 7'b1111000;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0010000;
    localparam logic [6:0] SEG_DASH  = 7'b0111111;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    localparam logic [15:0] LOW_THRESH = 16'h0200;

    typedef enum logic [1:0] {
        STEADY = 2'd0,
        LOW    = 2'd1,
        ZERO   = 2'd2
    } mode_t;

    // A value with any non-BCD digit is not a real time, so it never flashes.
    function automatic mode_t compute_mode(input logic [15:0] value);
        logic invalid;
        invalid = (value[15:12] > 4'd9) || (value[11:8] > 4'd9) ||
                  (value[7:4]   > 4'd9) || (value[3:0]  > 4'd9);
        if (invalid || value >= LOW_THRESH)
            return STEADY;
        else if (value == 16'h0000)
            return ZERO;
        else
            return LOW;
    endfunction

endpackage

// File: rtl/proj4_display_bcd_to_seg7.sv
// BCD nibble to active-low seven-segment pattern; non-BCD codes show a dash.
// Shared with the top-level debug display.
module bcd_to_seg7
    import proj4_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] seg
);

    always_comb begin
        // NOTE: the default arm assigns seg on every path, so no latch is inferred.
        case (nibble)
            4'd0:    seg = SEG_0;
            4'd1:    seg = SEG_1;
            4'd2:    seg = SEG_2;
            4'd3:    seg = SEG_3;
            4'd4:    seg = SEG_4;
            4'd5:    seg = SEG_5;
            4'd6:    seg = SEG_6;
            4'd7:    seg = SEG_7;
            4'd8:    seg = SEG_8;
            4'd9:    seg = SEG_9;
            default: seg = SEG_DASH;
        endcase
    end

endmodule

// File: rtl/proj4_display.sv
// Four-digit multiplexed seven-segment driver with the meter blink policy:
// steady at 0200+, 1 s flash for 0001..0199, 0.5 s flash at 0000.
module proj4_display
    import proj4_pkg::*;
#(
    parameter int REFRESH_DIV  = 100000,
    parameter int HALF_SEC_DIV = 50000000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] d,
    output logic [3:0]  an,
    output logic [6:0]  seg,
    output logic        dp
);

    localparam int RW = (REFRESH_DIV  > 1) ? $clog2(REFRESH_DIV)  : 1;
    localparam int HW = (HALF_SEC_DIV > 1) ? $clog2(HALF_SEC_DIV) : 1;
    localparam logic [RW-1:0] R_LAST = RW'(REFRESH_DIV - 1);
    localparam logic [HW-1:0] H_LAST = HW'(HALF_SEC_DIV - 1);

    logic [15:0]   d_q;
    logic [RW-1:0] rcnt;
    logic [1:0]    idx;
    logic [HW-1:0] hcnt;
    logic [1:0]    phase;
    mode_t         mode_q;
    mode_t         mode_next;
    logic          blank;
    logic [3:0]    nibble;
    logic [6:0]    digit_seg;

    assign dp        = 1'b1;
    assign mode_next = compute_mode(d_q);
    assign nibble    = d_q[{idx, 2'b00} +: 4];

    always_comb begin
        blank = 1'b0;
        case (mode_q)
            LOW:     blank = phase[1];
            ZERO:    blank = phase[0];
            default: blank = 1'b0;
        endcase
    end

    bcd_to_seg7 u_dec (
        .nibble (nibble),
        .seg    (digit_seg)
    );

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            d_q  <= 16'h0000;
            rcnt <= '0;
            idx  <= 2'd0;
        end else begin
            d_q <= d;
            if (rcnt == R_LAST) begin
                rcnt <= '0;
                idx  <= idx + 2'd1;
            end else begin
                rcnt <= rcnt + 1'b1;
            end
        end
    end

    // A mode change restarts the blink so the new mode opens in its ON phase.
    always_ff @(posedge clk) begin
        if (reset) begin
            mode_q <= STEADY;
            hcnt   <= '0;
            phase  <= 2'd0;
        end else if (mode_q != mode_next) begin
            mode_q <= mode_next;
            hcnt   <= '0;
            phase  <= 2'd0;
        end else if (mode_q == STEADY) begin
            hcnt  <= '0;
            phase <= 2'd0;
        end else if (hcnt == H_LAST) begin
            hcnt  <= '0;
            phase <= phase + 2'd1;
        end else begin
            hcnt <= hcnt + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            an  <= 4'b1111;
            seg <= SEG_BLANK;
        end else if (blank) begin
            an  <= 4'b1111;
            seg <= SEG_BLANK;
        end else begin
            an  <= ~(4'b0001 << idx);
            seg <= digit_seg;
        end
    end

endmodule

// File: tb/tb_proj4_display.sv
// Directed bench for proj4_display with REFRESH_DIV=4, HALF_SEC_DIV=8.
module tb_proj4_display;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] d;
    logic [3:0]  an;
    logic [6:0]  seg;
    logic        dp;

    int n_cmp = 0;
    int n_bad = 0;

    localparam logic [6:0] P0 = 7'b1000000;
    localparam logic [6:0] P1 = 7'b1111001;
    localparam logic [6:0] P2 = 7'b0100100;
    localparam logic [6:0] P3 = 7'b0110000;
    localparam logic [6:0] P4 = 7'b0011001;
    localparam logic [6:0] P5 = 7'b0010010;
    localparam logic [6:0] PD = 7'b0111111;
    localparam logic [6:0] PB = 7'b1111111;

    proj4_display #(.REFRESH_DIV(4), .HALF_SEC_DIV(8)) dut (
        .clk   (clk),
        .reset (reset),
        .d     (d),
        .an    (an),
        .seg   (seg),
        .dp    (dp)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Length of the run of samples whose blank state equals want, starting now.
    task automatic count_run(input bit want, input int max, output int n);
        n = 0;
        while (((an === 4'b1111) == want) && n < max) begin
            n++;
            tick();
        end
    endtask

    task automatic wait_blank(input int max, output int n);
        n = 0;
        while (an !== 4'b1111 && n < max) begin
            n++;
            tick();
        end
    endtask

    initial begin
        int n;
        logic [3:0] exp_an;
        logic [6:0] exp_seg;

        reset = 1'b1;
        d     = 16'h1234;

        // Reset held for three cycles.
        for (int i = 0; i < 3; i++) begin
            tick();
            check("reset_an", {12'h0, an}, 16'h000F);
            check("reset_seg", {9'h0, seg}, {9'h0, PB});
            check("reset_dp", {15'h0, dp}, 16'h0001);
        end

        // Scan after release: 4 cycles per digit, ones digit first.
        reset = 1'b0;
        for (int j = 1; j <= 16; j++) begin
            tick();
            case ((j - 1) / 4)
                0:       begin exp_an = 4'b1110; exp_seg = P4; end
                1:       begin exp_an = 4'b1101; exp_seg = P3; end
                2:       begin exp_an = 4'b1011; exp_seg = P2; end
                default: begin exp_an = 4'b0111; exp_seg = P1; end
            endcase
            check("scan_an", {12'h0, an}, {12'h0, exp_an});
            // First lit cycle still reflects the reset value of the input register.
            if (j >= 2) check("scan_seg", {9'h0, seg}, {9'h0, exp_seg});
        end

        // STEADY: never blank, exactly one digit enabled.
        d = 16'h0200;
        for (int i = 0; i < 200; i++) begin
            tick();
            check("steady_onehot", {15'h0, ($countones(~an) == 1)}, 16'h0001);
        end

        // LOW: first blank 19 samples after the change, then 16/16 flashing.
        d = 16'h0150;
        n = 0;
        for (int j = 1; j <= 40; j++) begin
            tick();
            if (an === 4'b1111) begin
                n = j;
                break;
            end
        end
        check("low_first_blank", 16'(n), 16'd19);
        count_run(1'b1, 40, n);
        check("low_blank_run", 16'(n), 16'd16);
        count_run(1'b0, 40, n);
        check("low_lit_run", 16'(n), 16'd16);
        count_run(1'b1, 40, n);
        check("low_blank_run2", 16'(n), 16'd16);

        // ZERO: 8 lit / 8 blank.
        d = 16'h0000;
        wait_blank(40, n);
        check("zero_reach_blank", {12'h0, an}, 16'h000F);
        count_run(1'b1, 40, n);
        check("zero_blank_run", 16'(n), 16'd8);
        count_run(1'b0, 40, n);
        check("zero_lit_run", 16'(n), 16'd8);

        // Mode change while blank: relight on the third cycle, lit for 16.
        check("zero_is_blank", {12'h0, an}, 16'h000F);
        d = 16'h0001;
        n = 0;
        for (int j = 1; j <= 10; j++) begin
            tick();
            if (an !== 4'b1111) begin
                n = j;
                break;
            end
        end
        check("relight_delay", 16'(n), 16'd3);
        count_run(1'b0, 40, n);
        check("relight_lit_run", 16'(n), 16'd16);

        // Invalid digit: dash on digit 1, no blanking.
        d = 16'h00A5;
        for (int i = 0; i < 3; i++) tick();
        for (int i = 0; i < 48; i++) begin
            case (an)
                4'b1110: exp_seg = P5;
                4'b1101: exp_seg = PD;
                4'b1011: exp_seg = P0;
                4'b0111: exp_seg = P0;
                default: exp_seg = PB;
            endcase
            check("invalid_not_blank", {15'h0, (an !== 4'b1111)}, 16'h0001);
            check("invalid_seg", {9'h0, seg}, {9'h0, exp_seg});
            tick();
        end

        // Mid-operation reset during a ZERO blank phase.
        d = 16'h0000;
        wait_blank(60, n);
        check("midrst_reach_blank", {12'h0, an}, 16'h000F);
        tick();
        tick();
        reset = 1'b1;
        tick();
        check("midrst_an", {12'h0, an}, 16'h000F);
        check("midrst_seg", {9'h0, seg}, {9'h0, PB});
        reset = 1'b0;
        tick();
        tick();
        check("midrst_digit0_an", {12'h0, an}, 16'h000E);
        check("midrst_digit0_seg", {9'h0, seg}, {9'h0, P0});
        count_run(1'b0, 40, n);
        check("midrst_lit_run", 16'(n), 16'd8);
        count_run(1'b1, 40, n);
        check("midrst_blank_run", 16'(n), 16'd8);
        check("final_dp", {15'h0, dp}, 16'h0001);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/proj4_display.md
# proj4_display

Four-digit multiplexed seven-segment driver for the parking-meter datapath. It consumes the 16-bit packed BCD remaining-time value produced by the meter counter, one nibble per digit, and scans it onto the common-anode board display. It applies the meter's blink policy: steady at 0200 and above, slow flash from 0001 to 0199, fast flash at 0000. It sits between the counter's BCD output and the top-level pins.

## Interface
- `REFRESH_DIV`, default 100000: clk cycles per digit slot. At 100 MHz this gives a 1 kHz slot rate.
- `HALF_SEC_DIV`, default 50000000: clk cycles per half-second tick.
- `clk` input, 1 bit: system clock. All logic is on its rising edge.
- `reset` input, 1 bit: synchronous, active-high reset.
- `d` input, 16 bits: packed BCD value. `d[15:12]` is the thousands digit and `d[3:0]` is the ones digit.
- `an` output, 4 bits: digit enables, active-low. `an[0]` selects the rightmost digit.
- `seg` output, 7 bits: segments {g,f,e,d,c,b,a}, active-low.
- `dp` output, 1 bit: decimal point, active-low. It is always 1 (off) in this block.

## Operation
- `d` is registered every cycle into `d_q`. All decoding uses `d_q`.
- **Refresh counter.** Counts 0..REFRESH_DIV-1. At wrap, the 2-bit scan index advances in the order 0→1→2→3→0.
- **Scan index i.** Selects nibble `d_q[4i+3:4i]` and drives `an` low on bit i only.
- **Segment decode.** Nibbles 0–9 map to standard digit patterns. Nibbles 10–15 show a dash: only g lit, so `seg`=7'b0111111. Leading zeros are displayed.
- **Half-second counter.** Counts 0..HALF_SEC_DIV-1. Each wrap is one tick. Each tick increments the 2-bit `phase`.
- **Mode FSM.** Mode is a function of `d_q`:
  - STEADY: `d_q` ≥ 16'h0200, or any digit above 9.
  - LOW: 16'h0001 ≤ `d_q` ≤ 16'h0199.
  - ZERO: `d_q` == 16'h0000.
- **Blank rule.**
  - STEADY: never blank.
  - LOW: blank while `phase[1]`==1, giving 1 s on and 1 s off.
  - ZERO: blank while `phase[0]`==1, giving 0.5 s on and 0.5 s off.
- **While blank:** `an`=4'b1111 and `seg`=7'h7F. Scanning continues internally.
- **Mode change.** Whenever the registered mode differs from the newly computed mode, the next cycle clears the half-second counter and `phase` to 0. The new mode therefore always starts in its ON phase.
- In STEADY, the half-second counter and `phase` are held at 0.

## Timing
- **Reset values** (applied on the first edge with `reset`=1):
  - `an`=4'b1111, `seg`=7'h7F, `dp`=1.
  - Scan index 0, both counters 0, `phase` 0.
  - Mode STEADY, `d_q`=0.
- **Reset release.** The mode is recomputed on the first edge after release. A `d` of 0 therefore enters ZERO with a phase clear on that edge.
- **Outputs.** `an` and `seg` are registered. From a scan index change to the `an`/`seg` update is 1 cycle. From a `d` change to the segment pattern update is 2 cycles: `d_q` then the output register.
- **Slot timing.** Each digit is enabled for exactly REFRESH_DIV cycles. The full frame is 4×REFRESH_DIV cycles.
- **Simultaneous events.**
  - Refresh wrap and half-second tick on the same cycle are independent; both take effect.
  - A mode change on a tick cycle: the phase clear wins over the increment.
- **Reset mid-frame.** Reset overrides everything. Scanning restarts at digit 0 on the cycle after `reset` falls.
- **Counter widths.** Wide enough for each DIV−1 value (`$clog2`). Equality compare at DIV−1; no terminal-count overflow.

## Structure
- **Shared package `proj4_pkg`:**
  - Active-low segment constants SEG_0..SEG_9, SEG_DASH, SEG_BLANK.
  - Mode enum {STEADY, LOW, ZERO}.
  - LOW_THRESH=16'h0200.
- **One sub-module `bcd_to_seg7`.** Combinational: 4-bit nibble in, 7-bit active-low pattern out. It is reused by the top-level debug display.
- **Top level.** Holds the two counters, the scan index, the mode/phase FSM and the output registers.

## Test plan
All scenarios use REFRESH_DIV=4 and HALF_SEC_DIV=8.
- **Reset:** hold `reset` for 3 cycles with `d`=16'h1234. Required: `an`=4'b1111 and `seg`=7'h7F while held. After release, `an` cycles 1110→1101→1011→0111, 4 cycles each. `seg` shows 4, 3, 2, 1 (`seg`=7'b0011001 for 4).
- **STEADY:** `d`=16'h0200 for 200 cycles. Required: no blank cycles; `an` always has exactly one 0.
- **LOW:** `d`=16'h0150. Required: lit for 16 cycles, then blank (`an`=4'b1111) for 16 cycles, repeating.
- **ZERO and mode change:** `d`=16'h0000. Required: 8 cycles lit, 8 blank, repeating. Then change `d` to 16'h0001 while blank. Required: the display relights within 3 cycles and stays lit for 16 cycles.
- **Invalid digit:** `d`=16'h00A5. Required: digit 1 shows `seg`=7'b0111111; mode is STEADY, so no blanking.
- **Mid-operation reset:** `d`=16'h0000. Assert `reset` for 1 cycle during a blank phase. Required: outputs blank on the reset edge. Digit 0 is lit (pattern 0) 2 cycles after release, and phase restarts with 8 lit cycles.
